// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counter sequencer and its counter datapath.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// WIDTH-bit synchronous down counter; load beats enable, reset clears.
// One-cycle update latency, no backpressure.
module sync_down_counter #(
    parameter int WIDTH = down_counter_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = q_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/down_counter_ctrl.sv
// Start/pause/abort sequencer owning the counter's load and enable; one-shot or periodic.
// Outputs registered one edge after the sampled inputs; no backpressure beyond the ack handshake in DONE.
module down_counter_ctrl
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             pause,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;

    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_zero;

    assign cnt_zero = (q == '0);

    // Abort clears the count through a load of zero rather than a separate clear.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_d    = load_val;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_load = 1'b1;
                end else if (!pause) begin
                    if (!cnt_zero) begin
                        cnt_en = 1'b1;
                    end else if (mode_q == MODE_PERIODIC) begin
                        cnt_load = 1'b1;
                        cnt_d    = reload_q;
                    end
                end
            end
            PAUSED: begin
                if (abort) begin
                    cnt_load = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        reload_q <= load_val;
                        mode_q   <= mode;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (pause) begin
                        state_q <= PAUSED;
                    end else if (cnt_zero) begin
                        tc_q <= 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!pause) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sync_down_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .d    (cnt_d),
        .q    (q)
    );

    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Scoreboarded bench for down_counter_ctrl: directed scenarios then random traffic.
module tb_down_counter_ctrl;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] load_val;
    logic         mode;
    logic         pause;
    logic         abort;
    logic         ack;
    logic [W-1:0] q;
    logic         busy;
    logic         tc;
    logic         done;

    always #5 clk = ~clk;

    down_counter_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .mode     (mode),
        .pause    (pause),
        .abort    (abort),
        .ack      (ack),
        .q        (q),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         tc;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    // Reference model: what the timer is doing, how many ticks remain, and the captured job.
    typedef enum int {M_IDLE, M_COUNTING, M_FROZEN, M_FINISHED} activity_t;
    activity_t m_act    = M_IDLE;
    int        m_left   = 0;
    int        m_reload = 0;
    bit        m_repeat = 1'b0;

    function automatic void chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, n_cycle, got, want);
        end
    endfunction

    task automatic drive(input bit r, input bit s, input int lv, input bit md,
                         input bit p, input bit a, input bit k);
        bit   expired;
        exp_t e;
        @(negedge clk);
        rst      = r;
        start    = s;
        load_val = lv[W-1:0];
        mode     = md;
        pause    = p;
        abort    = a;
        ack      = k;
        expired  = 1'b0;
        if (r) begin
            m_act    = M_IDLE;
            m_left   = 0;
            m_reload = 0;
            m_repeat = 1'b0;
        end else begin
            case (m_act)
                M_IDLE: if (s) begin
                    m_left   = lv % (1 << W);
                    m_reload = m_left;
                    m_repeat = md;
                    m_act    = M_COUNTING;
                end
                M_COUNTING: begin
                    if (a) begin
                        m_act  = M_IDLE;
                        m_left = 0;
                    end else if (p) begin
                        m_act = M_FROZEN;
                    end else if (m_left > 0) begin
                        m_left = m_left - 1;
                    end else begin
                        expired = 1'b1;
                        if (m_repeat) m_left = m_reload;
                        else          m_act  = M_FINISHED;
                    end
                end
                M_FROZEN: begin
                    if (a) begin
                        m_act  = M_IDLE;
                        m_left = 0;
                    end else if (!p) begin
                        m_act = M_COUNTING;
                    end
                end
                M_FINISHED: if (k) m_act = M_IDLE;
                default: m_act = M_IDLE;
            endcase
        end
        e.q    = W'(m_left);
        e.busy = (m_act == M_COUNTING) || (m_act == M_FROZEN);
        e.tc   = expired;
        e.done = (m_act == M_FINISHED);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit s);
        for (int i = 0; i < n; i++) drive(0, s, 0, 0, 0, 0, 0);
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 40 && m_left != target; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q",    int'(q),    int'(e.q));
                chk("busy", int'(busy), int'(e.busy));
                chk("tc",   int'(tc),   int'(e.tc));
                chk("done", int'(done), int'(e.done));
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; load_val = '0; mode = 1'b0;
        pause = 1'b0; abort = 1'b0; ack = 1'b0;

        // Reset dominates a pending start
        drive(1, 1, 5, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0, 0);
        idle(1, 0);

        // One-shot N=5, start held through DONE, ack coinciding with start
        drive(0, 1, 5, 0, 0, 0, 0);
        idle(9, 1);
        drive(0, 1, 3, 1, 0, 0, 1);
        idle(2, 0);

        // Periodic N=2 then abort at q=1
        drive(0, 1, 2, 1, 0, 0, 0);
        idle(6, 0);
        run_until(1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);

        // Pause one-shot N=6 at q=3 for 4 cycles
        drive(0, 1, 6, 0, 0, 0, 0);
        run_until(3);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0, 0);
        idle(6, 0);
        drive(0, 0, 0, 0, 0, 0, 1);

        // N=0 one-shot, then N=0 periodic
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(2, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0, 0, 0);
        idle(4, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Pause and abort together in RUN
        drive(0, 1, 7, 0, 0, 0, 0);
        idle(2, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        idle(1, 0);

        // Pause while q=0 suppresses expiry; abort from PAUSED
        drive(0, 1, 2, 0, 0, 0, 0);
        run_until(0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(2, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);

        // Reset mid-RUN at q=4, and mid-PAUSED
        drive(0, 1, 6, 1, 0, 0, 0);
        run_until(4);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 6, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        idle(1, 0);

        // Random traffic; load_val and mode wander freely after capture
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 30,
                  int'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 30);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
# down_counter_ctrl

Programmable sequencer for a WIDTH-bit synchronous down counter. It accepts a start command with a load value and an operating mode (one-shot or periodic). It runs the count with pause and abort control, emits a terminal-count pulse, and holds a completion flag until the requester acknowledges it. It sits between the requesting logic and the counter datapath, and owns the counter's load and enable.

## Interface
- WIDTH, 3: counter width in bits.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start request; honoured only in IDLE.
- load_val  in  WIDTH  initial and reload count N; captured when start is honoured.
- mode  in  1  0 = one-shot, 1 = periodic; captured with load_val.
- pause  in  1  level; freezes the count while high.
- abort  in  1  terminates RUN or PAUSED.
- ack  in  1  clears DONE.
- q  out  WIDTH  current count.
- busy  out  1  high in RUN and PAUSED.
- tc  out  1  registered one-cycle terminal-count pulse.
- done  out  1  high while in DONE.

## Operation
- States:
  - IDLE: start → RUN. On that edge: q ← load_val, reload register ← load_val, mode register ← mode.
  - RUN, priority abort > pause > count:
    - abort → IDLE, q ← 0, no tc.
    - pause → PAUSED, q held.
    - q != 0 → q ← q−1.
    - q == 0 is expiry: tc ← 1. One-shot → DONE, q stays 0. Periodic → q ← reload value, stay in RUN.
  - PAUSED:
    - abort → IDLE, q ← 0.
    - pause low → RUN, no decrement on this edge.
    - Otherwise hold.
  - DONE: ack → IDLE. start is ignored in DONE, including when it coincides with ack.
- Period is N+1 cycles. N = 0 expires on the first RUN edge (period 1). No special case for N = 0.
- start is ignored outside IDLE. load_val and mode changes after capture have no effect until the next honoured start.
- pause and abort are ignored in IDLE and DONE.
- tc is high only on the cycle after an expiry edge. It is never asserted by abort, pause or reset.
- Reset values: state IDLE, q = 0, busy = 0, tc = 0, done = 0, reload = 0, mode register = 0. rst overrides every input, including mid-RUN and mid-PAUSED.

## Timing
- start sampled at edge E0 → q = N and busy = 1 after E0.
- First decrement at E1.
- One-shot expiry at edge E(N+1) → tc = 1 and done = 1 after E(N+1). tc drops after E(N+2); done stays high.
- Periodic: tc pulses after E(N+1), E(2N+2), and so on. q reloads to N on the same edge as each expiry.
- busy, done and tc are all decoded or registered from state; none is combinational from inputs.
- ack sampled at edge Ek → done = 0, busy = 0 after Ek. A new start is accepted from edge Ek+1 onward.
- pause or abort takes effect on the first edge at which it is sampled high. No decrement occurs on that edge.

## Structure
- Shared package down_counter_pkg:
  - state enum {IDLE, RUN, PAUSED, DONE};
  - mode constants MODE_ONESHOT = 0, MODE_PERIODIC = 1;
  - default WIDTH.
- Sub-module sync_down_counter (WIDTH):
  - inputs clk, rst, load, en, d; output q;
  - load has priority over en; clr via rst only;
  - abort clear is done with load and d = 0.
- The controller holds the FSM, reload and mode registers, and the tc register, and drives load and en into sync_down_counter.

## Test plan
1. Reset: assert rst for 2 cycles with start = 1 and load_val = 5 → q = 0, busy = 0, tc = 0, done = 0; state stays IDLE.
2. One-shot, N = 5: start at E0 → q sequence 5,4,3,2,1,0. tc = 1 for exactly one cycle after E6. done = 1 until ack. start = 1 held in DONE is ignored. ack → busy = 0, done = 0.
3. Periodic, N = 2: q sequence 2,1,0,2,1,0,2 with tc every 3 cycles. Then abort at q = 1 → q = 0, IDLE, busy = 0, no tc.
4. Pause, one-shot N = 6: raise pause while q = 3 and hold it for 4 cycles → q stays 3 and busy = 1. Drop pause → q = 3 for one more edge, then 2,1,0, then tc and done.
5. N = 0, one-shot → tc and done after E1. The same test in periodic mode → tc high continuously, q = 0.
6. Simultaneous events:
   - pause and abort together in RUN → abort wins.
   - pause while q = 0 → no expiry.
   - rst at q = 4 mid-RUN → all outputs reset after the next edge.
